// File: rtl/ahb_splitter_1m4s_if.sv
// Bus bundle between one AHB-Lite master port, the splitter and four slaves.
// The splitter uses the slave modport; whoever drives the master port uses the master modport.
interface ahb_splitter_1m4s_if #(
    parameter int unsigned SZ = 64
) ();
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [SZ-1:0] HWDATA;
    logic          HREADY;
    logic [SZ-1:0] HRDATA;

    logic [3:0]    HSEL_S;
    logic [31:0]   HADDR_S;
    logic [1:0]    HTRANS_S;
    logic          HWRITE_S;
    logic [2:0]    HSIZE_S;
    logic [SZ-1:0] HWDATA_S;
    logic          HREADY_S;
    logic          HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2, HREADYOUT_S3;
    logic [SZ-1:0] HRDATA_S0, HRDATA_S1, HRDATA_S2, HRDATA_S3;

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        input  HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2, HREADYOUT_S3,
        input  HRDATA_S0, HRDATA_S1, HRDATA_S2, HRDATA_S3,
        output HREADY, HRDATA, HSEL_S, HADDR_S, HTRANS_S, HWRITE_S, HSIZE_S, HWDATA_S, HREADY_S
    );

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        output HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2, HREADYOUT_S3,
        output HRDATA_S0, HRDATA_S1, HRDATA_S2, HRDATA_S3,
        input  HREADY, HRDATA, HSEL_S, HADDR_S, HTRANS_S, HWRITE_S, HSIZE_S, HWDATA_S, HREADY_S
    );
endinterface

// File: rtl/ahb_splitter_1m4s.sv
// AHB-Lite 1-master/4-slave address decoder and read-back mux with a logging default slave.
module ahb_splitter_1m4s #(
    parameter int unsigned   SZ        = 64,
    parameter logic [3:0]    S0_BASE   = 4'h0,
    parameter logic [3:0]    S1_BASE   = 4'h2,
    parameter logic [3:0]    S2_BASE   = 4'h4,
    parameter logic [3:0]    S3_BASE   = 4'h8,
    parameter logic [SZ-1:0] DEF_RDATA = '0
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    ahb_splitter_1m4s_if.slave        bus,
    output logic [7:0]                DEF_CNT,
    output logic [31:0]               DEF_ADDR
);

    logic [3:0]  hsel;
    logic        def_hit;
    logic [4:0]  dsel_d, dsel_q;
    logic [7:0]  def_cnt_d, def_cnt_q;
    logic [31:0] def_addr_d, def_addr_q;

    // Lowest index wins when bases overlap, so at most one select is ever set.
    always_comb begin
        hsel    = 4'b0000;
        def_hit = 1'b0;
        if (bus.HTRANS[1]) begin
            if (bus.HADDR[31:28] == S0_BASE)      hsel[0] = 1'b1;
            else if (bus.HADDR[31:28] == S1_BASE) hsel[1] = 1'b1;
            else if (bus.HADDR[31:28] == S2_BASE) hsel[2] = 1'b1;
            else if (bus.HADDR[31:28] == S3_BASE) hsel[3] = 1'b1;
            else                                  def_hit = 1'b1;
        end
    end

    always_comb begin
        bus.HREADY = 1'b1;
        bus.HRDATA = '0;
        case (dsel_q)
            5'b00001: begin bus.HREADY = bus.HREADYOUT_S0; bus.HRDATA = bus.HRDATA_S0; end
            5'b00010: begin bus.HREADY = bus.HREADYOUT_S1; bus.HRDATA = bus.HRDATA_S1; end
            5'b00100: begin bus.HREADY = bus.HREADYOUT_S2; bus.HRDATA = bus.HRDATA_S2; end
            5'b01000: begin bus.HREADY = bus.HREADYOUT_S3; bus.HRDATA = bus.HRDATA_S3; end
            5'b10000: begin bus.HREADY = 1'b1;             bus.HRDATA = DEF_RDATA;     end
            default:  begin bus.HREADY = 1'b1;             bus.HRDATA = '0;            end
        endcase
    end

    always_comb begin
        dsel_d     = dsel_q;
        def_cnt_d  = def_cnt_q;
        def_addr_d = def_addr_q;
        if (bus.HREADY) begin
            dsel_d = {def_hit, hsel};
            if (def_hit) begin
                def_addr_d = bus.HADDR;
                if (def_cnt_q != 8'hFF) def_cnt_d = def_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dsel_q     <= 5'b00000;
            def_cnt_q  <= 8'h00;
            def_addr_q <= 32'h0;
        end else begin
            dsel_q     <= dsel_d;
            def_cnt_q  <= def_cnt_d;
            def_addr_q <= def_addr_d;
        end
    end

    assign bus.HSEL_S   = hsel;
    assign bus.HADDR_S  = bus.HADDR;
    assign bus.HTRANS_S = bus.HTRANS;
    assign bus.HWRITE_S = bus.HWRITE;
    assign bus.HSIZE_S  = bus.HSIZE;
    assign bus.HWDATA_S = bus.HWDATA;
    assign bus.HREADY_S = bus.HREADY;
    assign DEF_CNT      = def_cnt_q;
    assign DEF_ADDR     = def_addr_q;

endmodule

// File: tb/tb_ahb_splitter_1m4s.sv
// Directed bench for ahb_splitter_1m4s: vector table plus reset, saturation and async-reset sequences.
module tb_ahb_splitter_1m4s;

    logic        HCLK;
    logic        HRESETn;
    logic [7:0]  DEF_CNT;
    logic [31:0] DEF_ADDR;
    int          checks;
    int          errors;

    ahb_splitter_1m4s_if #(.SZ(64)) bus ();

    ahb_splitter_1m4s #(.SZ(64)) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .bus      (bus.slave),
        .DEF_CNT  (DEF_CNT),
        .DEF_ADDR (DEF_ADDR)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    localparam logic [63:0] RD0 = 64'h1111;
    localparam logic [63:0] RD1 = 64'hA5A5;
    localparam logic [63:0] RD2 = 64'h2222;
    localparam logic [63:0] RD3 = 64'h3333_3333;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [3:0]  rdy;
        logic [3:0]  hsel;
        logic        hready;
        logic [63:0] hrdata;
        logic [4:0]  dsel;
        logic [7:0]  cnt;
        logic [31:0] daddr;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] addr, input logic [1:0] trans, input logic write,
                         input logic [3:0] rdy);
        bus.HADDR        = addr;
        bus.HTRANS       = trans;
        bus.HWRITE       = write;
        bus.HSIZE        = 3'b011;
        bus.HWDATA       = {32'hCAFE_0000, addr};
        bus.HREADYOUT_S0 = rdy[0];
        bus.HREADYOUT_S1 = rdy[1];
        bus.HREADYOUT_S2 = rdy[2];
        bus.HREADYOUT_S3 = rdy[3];
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.HRDATA_S0 = RD0;
        bus.HRDATA_S1 = RD1;
        bus.HRDATA_S2 = RD2;
        bus.HRDATA_S3 = RD3;

        //           addr          trans  wr    rdy      hsel     rdy_o hrdata dsel      cnt  daddr
        vecs[0]  = '{32'h2000_0010, 2'b10, 1'b0, 4'b1111, 4'b0010, 1'b1, 64'h0, 5'b00000, 8'd0, 32'h0};
        vecs[1]  = '{32'h0000_0000, 2'b00, 1'b0, 4'b1101, 4'b0000, 1'b0, RD1,   5'b00010, 8'd0, 32'h0};
        vecs[2]  = '{32'h0000_0000, 2'b00, 1'b0, 4'b1101, 4'b0000, 1'b0, RD1,   5'b00010, 8'd0, 32'h0};
        vecs[3]  = '{32'h0000_0000, 2'b00, 1'b0, 4'b1111, 4'b0000, 1'b1, RD1,   5'b00010, 8'd0, 32'h0};
        vecs[4]  = '{32'h0000_0000, 2'b10, 1'b1, 4'b1111, 4'b0001, 1'b1, 64'h0, 5'b00000, 8'd0, 32'h0};
        vecs[5]  = '{32'h8000_0004, 2'b10, 1'b0, 4'b1111, 4'b1000, 1'b1, RD0,   5'b00001, 8'd0, 32'h0};
        vecs[6]  = '{32'h0000_0000, 2'b00, 1'b0, 4'b1111, 4'b0000, 1'b1, RD3,   5'b01000, 8'd0, 32'h0};
        vecs[7]  = '{32'h4000_0000, 2'b10, 1'b0, 4'b1111, 4'b0100, 1'b1, 64'h0, 5'b00000, 8'd0, 32'h0};
        vecs[8]  = '{32'h0000_0040, 2'b10, 1'b0, 4'b1011, 4'b0001, 1'b0, RD2,   5'b00100, 8'd0, 32'h0};
        vecs[9]  = '{32'h0000_0040, 2'b10, 1'b0, 4'b1011, 4'b0001, 1'b0, RD2,   5'b00100, 8'd0, 32'h0};
        vecs[10] = '{32'h0000_0040, 2'b10, 1'b0, 4'b1111, 4'b0001, 1'b1, RD2,   5'b00100, 8'd0, 32'h0};
        vecs[11] = '{32'h0000_0000, 2'b00, 1'b0, 4'b1111, 4'b0000, 1'b1, RD0,   5'b00001, 8'd0, 32'h0};
        vecs[12] = '{32'hF000_0100, 2'b10, 1'b0, 4'b1111, 4'b0000, 1'b1, 64'h0, 5'b00000, 8'd0, 32'h0};
        vecs[13] = '{32'h2000_0000, 2'b01, 1'b0, 4'b1111, 4'b0000, 1'b1, 64'h0, 5'b10000, 8'd1,
                     32'hF000_0100};

        // Reset held with a live NONSEQ: decode still follows inputs, state stays cleared.
        HRESETn = 1'b0;
        drive(32'h2000_0000, 2'b10, 1'b0, 4'b1111);
        #2;
        chk("rst_hsel", 64'(bus.HSEL_S), 64'(4'b0010));
        chk("rst_hready", 64'(bus.HREADY), 64'(1'b1));
        chk("rst_hrdata", bus.HRDATA, 64'h0);
        chk("rst_cnt", 64'(DEF_CNT), 64'h0);
        chk("rst_daddr", 64'(DEF_ADDR), 64'h0);
        @(negedge HCLK);
        chk("rst_dsel", 64'(dut.dsel_q), 64'h0);
        drive(32'h0, 2'b00, 1'b0, 4'b1111);
        HRESETn = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(negedge HCLK);
            drive(vecs[i].addr, vecs[i].trans, vecs[i].write, vecs[i].rdy);
            #2;
            chk($sformatf("v%0d_hsel", i), 64'(bus.HSEL_S), 64'(vecs[i].hsel));
            chk($sformatf("v%0d_hready", i), 64'(bus.HREADY), 64'(vecs[i].hready));
            chk($sformatf("v%0d_hready_s", i), 64'(bus.HREADY_S), 64'(vecs[i].hready));
            chk($sformatf("v%0d_hrdata", i), bus.HRDATA, vecs[i].hrdata);
            chk($sformatf("v%0d_dsel", i), 64'(dut.dsel_q), 64'(vecs[i].dsel));
            chk($sformatf("v%0d_cnt", i), 64'(DEF_CNT), 64'(vecs[i].cnt));
            chk($sformatf("v%0d_daddr", i), 64'(DEF_ADDR), 64'(vecs[i].daddr));
            chk($sformatf("v%0d_haddr_s", i), 64'(bus.HADDR_S), 64'(vecs[i].addr));
            chk($sformatf("v%0d_hwrite_s", i), 64'(bus.HWRITE_S), 64'(vecs[i].write));
            chk($sformatf("v%0d_hwdata_s", i), bus.HWDATA_S, {32'hCAFE_0000, vecs[i].addr});
        end

        // 300 unmapped transfers on top of the one already logged.
        for (int i = 0; i < 300; i++) begin
            @(negedge HCLK);
            drive({4'hF, 28'(i * 4)}, 2'b10, 1'b0, 4'b1111);
            if (i == 100) chk("sat_mid_cnt", 64'(DEF_CNT), 64'd101);
            if (i == 254) chk("sat_edge_cnt", 64'(DEF_CNT), 64'd255);
        end
        @(negedge HCLK);
        drive(32'h0, 2'b00, 1'b0, 4'b1111);
        #2;
        chk("sat_cnt", 64'(DEF_CNT), 64'hFF);
        chk("sat_daddr", 64'(DEF_ADDR), 64'hF000_04AC);
        chk("sat_hready", 64'(bus.HREADY), 64'(1'b1));

        // Async reset in the middle of a stalled S2 data phase.
        @(negedge HCLK);
        drive(32'h4000_0008, 2'b10, 1'b0, 4'b1111);
        @(negedge HCLK);
        drive(32'h0, 2'b00, 1'b0, 4'b1011);
        #2;
        chk("mid_hready", 64'(bus.HREADY), 64'(1'b0));
        chk("mid_hrdata", bus.HRDATA, RD2);
        HRESETn = 1'b0;
        #1;
        chk("arst_dsel", 64'(dut.dsel_q), 64'h0);
        chk("arst_hready", 64'(bus.HREADY), 64'(1'b1));
        chk("arst_hrdata", bus.HRDATA, 64'h0);
        chk("arst_cnt", 64'(DEF_CNT), 64'h0);
        chk("arst_daddr", 64'(DEF_ADDR), 64'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
